// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment constants, active-low, Ca[0]=a .. Ca[6]=g
package seg_pkg;
  typedef enum int {SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G} seg_bit_e;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to active-low segment pattern
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[nib];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment scanner with framed updates, blanking and zero suppression
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS  = 8,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp_en,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  lz_blank,
  input  logic                  load,
  output logic [N_DIGITS-1:0]   AN,
  output logic [6:0]            Ca,
  output logic                  DP,
  output logic                  frame_done
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*N_DIGITS-1:0] pend_data, act_data;
  logic [N_DIGITS-1:0] pend_dp, pend_en, act_dp, act_en, vis;
  logic pend_valid, slot_end, commit, on, hz;
  logic [3:0] nib;
  logic [6:0] seg;
  assign slot_end = cnt == CW'(SCAN_DIV - 1);
  assign commit = slot_end && idx == IW'(N_DIGITS - 1) && pend_valid;
  assign nib = act_data[{idx, 2'b00} +: 4];
  assign on = int'(cnt) >= BLANK_CYC && vis[idx];
  seg_hex_decode u_dec (.nib(nib), .seg(seg));
  always_comb begin
    hz = 1'b1;
    vis = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      vis[i] = act_en[i] && !(lz_blank && i > 0 && hz && act_data[4*i +: 4] == 4'h0);
      hz = hz && (!act_en[i] || act_data[4*i +: 4] == 4'h0);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
      pend_valid <= 1'b0;
      act_data   <= '0;
      act_dp     <= '0;
      act_en     <= '0;
      AN         <= '1;
      Ca         <= SEG_OFF;
      DP         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) idx <= idx == IW'(N_DIGITS - 1) ? '0 : idx + IW'(1);
      if (commit) {act_data, act_dp, act_en} <= {pend_data, pend_dp, pend_en};
      if (load) {pend_data, pend_dp, pend_en} <= {data, dp_en, digit_en};
      pend_valid <= load || (pend_valid && !commit);
      frame_done <= commit;
      AN <= on ? ~(N_DIGITS'(1) << idx) : '1;
      Ca <= on ? seg : SEG_OFF;
      DP <= on ? ~act_dp[idx] : 1'b1;
    end
  end
endmodule
